spi_xfer_queue: RTL and testbench

Transfer scheduler that sits directly upstream of the four-slave SPI master subsystem. It buffers transfer requests (payload plus target slave index) in a request FIFO and issues them one at a time to the SPI master through its `data_in`/`tx_start` handshake. For each transfer it waits for the master's receive completion, captures the MISO word, and queues it with the slave index in a response FIFO for the consumer.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync_fifo.sv | 52 +++++
 rtl/spi_xfer_queue.sv | 154 +++++++++++++++
 tb/tb_spi_xfer_queue.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and defaults for the SPI transfer scheduler
// Contents:
//   SPI_BITS_SIZE / SPI_SLAVE_NUM  default word width and slave count
//   spi_xfer_state_t               scheduler FSM states
//   spi_rsp_t                      response entry {data, slave, err} at default widths
package spi_pkg;

  localparam int SPI_BITS_SIZE = 8;
  localparam int SPI_SLAVE_NUM = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    PUSH  = 2'd3
  } spi_xfer_state_t;

  typedef struct packed {
    logic [SPI_BITS_SIZE-1:0]         data;
    logic [$clog2(SPI_SLAVE_NUM)-1:0] slave;
    logic                             err;
  } spi_rsp_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - single-clock FIFO with wrap-bit pointers
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   push, push_data  write strobe and data (ignored while full)
//   pop              read strobe (ignored while empty)
//   head             entry at the read pointer, combinational
//   full, empty      occupancy flags decoded from the pointers
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  // Extra MSB distinguishes full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/spi_xfer_queue.sv
// rtl/spi_xfer_queue.sv - request/response scheduler in front of the SPI master
// Optional feature macro: SPI_XFER_TIMEOUT_EN (WAIT watchdog, err-flagged responses)
// Ports:
//   clk, reset_n                          clock, asynchronous active-low reset
//   req_valid/req_ready/req_data/req_slave  request push interface
//   rsp_valid/rsp_ready/rsp_data/rsp_slave/rsp_err  response pop interface
//   master_data_in, master_slave_sel, tx_start      issue side to the SPI master
//   master_rx_done, master_data_out                 completion side from the SPI master
//   busy                                  FSM not in IDLE
module spi_xfer_queue
  import spi_pkg::*;
#(
  parameter int  BITS_SIZE      = SPI_BITS_SIZE,
  parameter int  DEPTH          = 4,
  parameter int  SLAVE_NUM      = SPI_SLAVE_NUM,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int SW             = $clog2(SLAVE_NUM)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BITS_SIZE-1:0] req_data,
  input  logic [SW-1:0]        req_slave,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS_SIZE-1:0] rsp_data,
  output logic [SW-1:0]        rsp_slave,
  output logic                 rsp_err,
  output logic [BITS_SIZE-1:0] master_data_in,
  output logic [SW-1:0]        master_slave_sel,
  output logic                 tx_start,
  input  logic                 master_rx_done,
  input  logic [BITS_SIZE-1:0] master_data_out,
  output logic                 busy
);

  localparam int REQ_W = BITS_SIZE + SW;
`ifdef SPI_XFER_TIMEOUT_EN
  localparam int RSP_W = BITS_SIZE + SW + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
`else
  localparam int RSP_W = BITS_SIZE + SW;
`endif

  spi_xfer_state_t state_q, state_d;

  logic             req_full, req_empty;
  logic [REQ_W-1:0] req_head;
  logic             rsp_full, rsp_empty;
  logic [RSP_W-1:0] rsp_head;
  logic [RSP_W-1:0] rsp_push_data;
  logic [BITS_SIZE-1:0] rsp_data_q;
  logic             issue;
  logic             timeout_hit;

  // Issue only when the response has a guaranteed slot, so PUSH never stalls.
  assign issue     = (state_q == IDLE) && !req_empty && !rsp_full;
  assign req_ready = !req_full;
  assign rsp_valid = !rsp_empty;

`ifdef SPI_XFER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             rsp_err_q;

  // Fires in the last allowed WAIT cycle; rx_done in that same cycle still wins.
  assign timeout_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign rsp_push_data = {rsp_data_q, master_slave_sel, rsp_err_q};
  assign {rsp_data, rsp_slave, rsp_err} = rsp_head;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
  assign rsp_push_data  = {rsp_data_q, master_slave_sel};
  assign {rsp_data, rsp_slave} = rsp_head;
  assign rsp_err        = 1'b0;
`endif

  spi_sync_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_req_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (req_valid && req_ready),
    .push_data ({req_data, req_slave}),
    .pop       (issue),
    .head      (req_head),
    .full      (req_full),
    .empty     (req_empty)
  );

  spi_sync_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (state_q == PUSH),
    .push_data (rsp_push_data),
    .pop       (rsp_valid && rsp_ready),
    .head      (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (issue) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (master_rx_done || timeout_hit) state_d = PUSH;
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      tx_start         <= 1'b0;
      busy             <= 1'b0;
      master_data_in   <= '0;
      master_slave_sel <= '0;
      rsp_data_q       <= '0;
`ifdef SPI_XFER_TIMEOUT_EN
      rsp_err_q        <= 1'b0;
      tmo_cnt          <= '0;
`endif
    end else begin
      state_q  <= state_d;
      // Registered outputs are derived from the next state so they line up with it.
      tx_start <= (state_d == START);
      busy     <= (state_d != IDLE);
      if (issue) begin
        {master_data_in, master_slave_sel} <= req_head;
      end
      if (state_q == WAIT) begin
        if (master_rx_done) begin
          rsp_data_q <= master_data_out;
`ifdef SPI_XFER_TIMEOUT_EN
          rsp_err_q  <= 1'b0;
        end else if (timeout_hit) begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
`endif
        end
      end
`ifdef SPI_XFER_TIMEOUT_EN
      if (state_q == START) begin
        tmo_cnt <= '0;
      end else if (state_q == WAIT) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_xfer_queue.sv
// tb/tb_spi_xfer_queue.sv - directed scoreboard bench for spi_xfer_queue
module tb_spi_xfer_queue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_ready;
  logic [7:0] req_data;
  logic [1:0] req_slave;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [1:0] rsp_slave;
  logic       rsp_err;
  logic [7:0] master_data_in;
  logic [1:0] master_slave_sel;
  logic       tx_start;
  logic       master_rx_done;
  logic [7:0] master_data_out;
  logic       busy;

  logic model_rx_done;
  logic spur_rx_done;
  assign master_rx_done = model_rx_done | spur_rx_done;

  always #5 clk = ~clk;

  spi_xfer_queue #(
    .BITS_SIZE(8), .DEPTH(4), .SLAVE_NUM(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_data         (req_data),
    .req_slave        (req_slave),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_slave        (rsp_slave),
    .rsp_err          (rsp_err),
    .master_data_in   (master_data_in),
    .master_slave_sel (master_slave_sel),
    .tx_start         (tx_start),
    .master_rx_done   (master_rx_done),
    .master_data_out  (master_data_out),
    .busy             (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] slave;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   tx_count    = 0;
  int   rx_delay    = 20;
  bit   master_en   = 1'b1;

  // The SPI master returns a fixed transform of what it was sent.
  function automatic logic [7:0] miso_of(input logic [7:0] d);
    return d ^ 8'h99;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) if (tx_start === 1'b1) tx_count++;

  // SPI master model: answers rx_delay cycles after seeing tx_start, aborts on reset.
  initial begin
    bit aborted;
    model_rx_done   = 1'b0;
    master_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (master_en && reset_n && tx_start) begin
        aborted = 1'b0;
        for (int i = 0; i < rx_delay; i++) begin
          @(negedge clk);
          if (!reset_n) aborted = 1'b1;
        end
        if (!aborted) begin
          master_data_out = miso_of(master_data_in);
          model_rx_done   = 1'b1;
          @(negedge clk);
          model_rx_done   = 1'b0;
        end
      end
    end
  end

  task automatic push_req(input logic [7:0] d, input logic [1:0] s);
    int   n;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_data  = d;
    req_slave = s;
    while (!req_ready && n < 500) begin
      step();
      n++;
    end
    check("push_ready", req_ready, 1'b1);
    e.data  = miso_of(d);
    e.slave = s;
    e.err   = 1'b0;
    exp_q.push_back(e);
    step();
    req_valid = 1'b0;
  endtask

  task automatic pop_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 500) begin
      step();
      n++;
    end
    check({tag, "_valid"}, rsp_valid, 1'b1);
    check({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rsp_data, e.data);
      check({tag, "_slave"}, rsp_slave, e.slave);
      check({tag, "_err"}, rsp_err, e.err);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic wait_rx_done(input string tag);
    int n;
    n = 0;
    while (!master_rx_done && n < 200) begin
      step();
      n++;
    end
    check(tag, master_rx_done, 1'b1);
  endtask

  initial begin
    int   c0;
    exp_t e;
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_data     = 8'h00;
    req_slave    = 2'd0;
    rsp_ready    = 1'b0;
    spur_rx_done = 1'b0;
    repeat (3) step();

    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data_in", master_data_in, 8'h00);
    check("rst_slave_sel", master_slave_sel, 2'd0);
    check("rst_rsp_head", {rsp_data, rsp_slave, rsp_err}, 11'h000);
    reset_n = 1'b1;
    step();

    // Single transfer: latency, stable issue fields, response timing.
    rx_delay = 20;
    c0 = tx_count;
    push_req(8'hA5, 2'd2);
    check("t1_tx_start_pre", tx_start, 1'b0);
    step();
    check("t1_tx_start", tx_start, 1'b1);
    check("t1_busy", busy, 1'b1);
    check("t1_slave_sel", master_slave_sel, 2'd2);
    check("t1_data_in", master_data_in, 8'hA5);
    wait_rx_done("t1_rx_done_seen");
    check("t1_rsp_valid_m", rsp_valid, 1'b0);
    step();
    check("t1_rsp_valid_push", rsp_valid, 1'b0);
    step();
    check("t1_rsp_valid_m2", rsp_valid, 1'b1);
    check("t1_rsp_data_3c", rsp_data, 8'h3C);
    pop_rsp("t1");
    repeat (5) step();
    check("t1_one_pulse", tx_count - c0, 1);
    check("t1_idle", busy, 1'b0);

    // Five back-to-back requests with the consumer stalled.
    rx_delay = 5;
    c0 = tx_count;
    for (int i = 0; i < 5; i++) push_req(8'h40 + 8'(i), 2'(i));
    check("t2_req_full", req_ready, 1'b0);
    repeat (100) step();
    check("t2_four_issued", tx_count - c0, 4);
    check("t2_stalled_idle", busy, 1'b0);
    check("t2_req_room", req_ready, 1'b1);
    pop_rsp("t2_first");
    repeat (40) step();
    check("t2_fifth_issued", tx_count - c0, 5);
    for (int i = 0; i < 4; i++) pop_rsp("t2_drain");

    // Simultaneous push/pop on both queues.
    rx_delay = 3;
    push_req(8'h11, 2'd0);
    push_req(8'h22, 2'd1);
    repeat (30) step();
    rx_delay = 8;
    push_req(8'h33, 2'd2);
    push_req(8'h44, 2'd3);
    wait_rx_done("t3_rx_done_seen");
    step();
    e = exp_q.pop_front();
    check("t3_head_11", rsp_data, e.data);
    check("t3_head_11_slave", rsp_slave, e.slave);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t3_head_22", rsp_data, miso_of(8'h22));
    check("t3_req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_data  = 8'h55;
    req_slave = 2'd0;
    e.data = miso_of(8'h55);
    e.slave = 2'd0;
    e.err = 1'b0;
    exp_q.push_back(e);
    step();
    req_valid = 1'b0;
    check("t3_tx_start_44", tx_start, 1'b1);
    check("t3_data_in_44", master_data_in, 8'h44);
    for (int i = 0; i < 4; i++) pop_rsp("t3_drain");

    // Reset while WAITing discards everything.
    rx_delay = 30;
    push_req(8'h77, 2'd1);
    push_req(8'h78, 2'd2);
    repeat (6) step();
    check("t4_busy_wait", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("t4_rst_tx_start", tx_start, 1'b0);
    check("t4_rst_rsp_valid", rsp_valid, 1'b0);
    check("t4_rst_req_ready", req_ready, 1'b1);
    check("t4_rst_busy", busy, 1'b0);
    exp_q.delete();
    c0 = tx_count;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (40) step();
    check("t4_no_rsp", rsp_valid, 1'b0);
    check("t4_no_issue", tx_count - c0, 0);
    rx_delay = 4;
    push_req(8'h5A, 2'd3);
    pop_rsp("t4_5a");

    // Spurious rx_done while IDLE.
    c0 = tx_count;
    step();
    spur_rx_done = 1'b1;
    step();
    spur_rx_done = 1'b0;
    repeat (10) step();
    check("t5_no_rsp", rsp_valid, 1'b0);
    check("t5_idle", busy, 1'b0);
    check("t5_no_issue", tx_count - c0, 0);

`ifdef SPI_XFER_TIMEOUT_EN
    // Watchdog expiry after 16 WAIT cycles.
    master_en = 1'b0;
    push_req(8'h99, 2'd1);
    exp_q[exp_q.size()-1].data = 8'h00;
    exp_q[exp_q.size()-1].err  = 1'b1;
    step();
    check("t6_tx_start", tx_start, 1'b1);
    repeat (17) step();
    check("t6_before_limit", rsp_valid, 1'b0);
    step();
    check("t6_at_limit", rsp_valid, 1'b1);
    pop_rsp("t6_timeout");
    // rx_done in the limit cycle beats the watchdog.
    master_en = 1'b1;
    rx_delay  = 16;
    push_req(8'hC3, 2'd2);
    pop_rsp("t6_rx_wins");
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
